// File: rtl/reg_scoreboard_if.sv
// ==========================================================================
// Interface : reg_scoreboard_if
// Decode/writeback signal bundle for the register scoreboard.
// Rev       : 1.0
// ==========================================================================
`default_nettype none

interface reg_scoreboard_if #(
  parameter int CNT_W = 3
);
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic             issue_ready;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             stall;
  logic [CNT_W-1:0] outstanding;
  logic             wb_err;

  modport master (
    output issue_valid, issue_rd, wb_valid, wb_rd, rs1, rs2,
    input  issue_ready, rs1_busy, rs2_busy, stall, outstanding, wb_err
  );

  modport slave (
    input  issue_valid, issue_rd, wb_valid, wb_rd, rs1, rs2,
    output issue_ready, rs1_busy, rs2_busy, stall, outstanding, wb_err
  );
endinterface

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ==========================================================================
// Module : reg_scoreboard
// Pending-write scoreboard for multicycle ops; define SCOREBOARD_WB_BYPASS_EN
// to let a same-cycle writeback clear the source busy queries.
// Rev    : 1.0
// ==========================================================================
`default_nettype none

module reg_scoreboard #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input wire logic        clock,
  input wire logic        reset,
  reg_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] c_max_out = CNT_W'(MAX_OUT);

  logic [31:1]      r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wb_err;

  logic [31:0] w_busy;
  logic [31:1] w_set_vec;
  logic [31:1] w_clr_vec;
  logic        w_wb_hit;
  logic        w_wb_miss;
  logic        w_target_free;
  logic        w_room;
  logic        w_ready;
  logic        w_set;
  logic        w_rs1_busy;
  logic        w_rs2_busy;

  // Register 0 has no storage; the zero bit makes indexed reads of r0 free.
  assign w_busy = {r_busy, 1'b0};

  assign w_wb_hit  = sb.wb_valid & (sb.wb_rd != 5'd0) &  w_busy[sb.wb_rd];
  assign w_wb_miss = sb.wb_valid & (sb.wb_rd != 5'd0) & ~w_busy[sb.wb_rd];

  assign w_target_free = (sb.issue_rd == 5'd0) | ~w_busy[sb.issue_rd] |
                         (sb.wb_valid & (sb.wb_rd == sb.issue_rd));
  assign w_room        = (r_cnt < c_max_out) | w_wb_hit;
  assign w_ready       = w_target_free & w_room;
  assign w_set         = sb.issue_valid & w_ready & (sb.issue_rd != 5'd0);

  for (genvar g = 1; g < 32; g++) begin : g_dec
    assign w_set_vec[g] = w_set    & (sb.issue_rd == 5'(g));
    assign w_clr_vec[g] = w_wb_hit & (sb.wb_rd    == 5'(g));
  end

  // Set is applied after clear so a same-register re-issue stays busy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_busy   <= '0;
      r_cnt    <= '0;
      r_wb_err <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
      r_cnt  <= r_cnt + CNT_W'(w_set) - CNT_W'(w_wb_hit);
      if (w_wb_miss) begin
        r_wb_err <= 1'b1;
      end
    end
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign w_rs1_busy = w_busy[sb.rs1] & ~(sb.wb_valid & (sb.wb_rd == sb.rs1));
  assign w_rs2_busy = w_busy[sb.rs2] & ~(sb.wb_valid & (sb.wb_rd == sb.rs2));
`else
  assign w_rs1_busy = w_busy[sb.rs1];
  assign w_rs2_busy = w_busy[sb.rs2];
`endif

  assign sb.issue_ready = w_ready;
  assign sb.rs1_busy    = w_rs1_busy;
  assign sb.rs2_busy    = w_rs2_busy;
  assign sb.stall       = w_rs1_busy | w_rs2_busy | (sb.issue_valid & ~w_ready);
  assign sb.outstanding = r_cnt;
  assign sb.wb_err      = r_wb_err;

endmodule

`default_nettype wire

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks which architectural registers have a write pending from the multicycle multiply/divide unit, and answers source-register busy queries from decode. It is the write-side companion to the decode-stage register-number equality checks. Decode marks a destination register busy when it issues a long-latency op. Writeback clears it. Decode stalls while either source register is busy.

## Interface
- MAX_OUT, default 4: maximum simultaneously pending writes (1..31).
- CNT_W, default 3: width of the outstanding counter; must hold MAX_OUT.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- issue_valid  in  1  decode requests to mark issue_rd busy.
- issue_rd  in  5  destination register of the issuing op.
- issue_ready  out  1  issue is accepted this cycle if high.
- wb_valid  in  1  writeback of wb_rd completes this cycle.
- wb_rd  in  5  register being written back.
- rs1, rs2  in  5  source registers queried by decode.
- rs1_busy, rs2_busy  out  1  source has a pending write.
- stall  out  1  rs1_busy | rs2_busy | (issue_valid & ~issue_ready).
- outstanding  out  CNT_W  number of busy registers.
- wb_err  out  1  sticky flag: a writeback targeted a non-busy register.

## Operation
- State: busy[31:1], a CNT_W-bit counter, and the wb_err flag. Register 0 has no storage and always reads not-busy.
- Issue acceptance: a request is accepted when issue_valid & issue_ready.
- issue_ready is high when both hold:
  - the target is free or being freed: issue_rd==0, or busy[issue_rd]==0, or (wb_valid & wb_rd==issue_rd).
  - there is room: outstanding<MAX_OUT, or wb_valid is clearing a busy register this cycle.
- issue_ready is combinational from state and inputs.
- Accepted issue with issue_rd!=0 sets busy[issue_rd].
  - issue_rd==0 is accepted but changes no state.
- Writeback with wb_valid, wb_rd!=0 and busy[wb_rd]==1 clears busy[wb_rd].
- Writeback with wb_valid and busy[wb_rd]==0 (including wb_rd==0 when wb_rd!=0 is not busy) changes no busy bit. If wb_rd!=0, wb_err is set and stays high until reset.
- Same-cycle issue and writeback:
  - Same register: the register stays busy (the new pending write replaces the old one). outstanding is unchanged.
  - Different registers: both updates apply. outstanding is unchanged.
- Counter arithmetic: next = cur + set - clr, where set and clr are 1-bit terms counting only real state changes. The counter never wraps: acceptance is gated at MAX_OUT, and clr requires a busy bit.
- rs1_busy and rs2_busy are combinational reads of busy[], subject to the Configuration section. rs==0 always reads 0.

## Timing
- Reset (reset==0 at a rising edge):
  - busy all 0, outstanding 0, wb_err 0.
  - issue_ready is 1 whenever capacity allows (it is combinational).
  - Reset wins over a simultaneous issue or writeback.
- Set latency: an issue accepted at edge N shows rs_busy=1 from cycle N+1. A query in the issue cycle does not see its own issue.
- Clear latency: a writeback at edge N shows rs_busy=0 from cycle N+1, or in cycle N itself when bypass is enabled.
- Combinational paths: issue_ready, stall and rs*_busy depend combinationally on inputs. No input-to-output loop exists: issue_ready does not depend on issue_valid.
- Reset mid-operation: all pending writes are forgotten. A later writeback to a formerly busy register sets wb_err.

## Configuration
- SCOREBOARD_WB_BYPASS_EN defined:
  - rsX_busy is 0 when wb_valid & wb_rd==rsX, in the same cycle. The writeback data is forwarded by the bypass path.
  - This holds even if the same register is being re-issued that cycle, because the new write is visible only next cycle.
- Undefined: rsX_busy reflects registered busy[] only, so the consumer stalls one extra cycle after writeback.
- Issue-side behaviour is identical in both builds.

## Test plan
- Reset, then issue rd=5:
  - cycle 0: issue_ready=1, rs1=5 → rs1_busy=0.
  - cycle 1: rs1=5 → rs1_busy=1, stall=1, outstanding=1.
- With 5 busy, writeback wb_rd=5 while rs2=5:
  - bypass build: rs2_busy=0 same cycle.
  - non-bypass build: rs2_busy=1 that cycle and 0 next cycle. outstanding→0.
- Issue rd=3,7,9,11 (MAX_OUT=4), then request rd=12:
  - issue_ready=0, stall=1.
  - same request plus writeback of 7 that cycle → accepted, outstanding stays 4, busy{3,9,11,12}.
- With 8 busy, issue rd=8 with no writeback → issue_ready=0. Issue rd=8 with writeback rd=8 same cycle → accepted, busy[8] stays 1, outstanding unchanged.
- Issue rd=0 → accepted, outstanding=0, rs1=0 → rs1_busy=0. Writeback rd=0 → wb_err stays 0. Writeback of non-busy rd=14 → wb_err=1, held through 10 idle cycles.
- With 3 registers busy, drive reset=0 for one edge alongside issue rd=6 → outstanding=0, all busy 0, wb_err 0.
